// File: rtl/snd_ingen.sv
`timescale 1ns/1ps
// snd_ingen: serial audio capture receiver.
// Deserializes a left-justified, MSB-first stereo stream framed by SND_LRCLK
// (2*HALF_BITS BCLKs per frame) and pushes {left, right} words into the
// capture FIFO, with optional decimation, overflow counting and sync checking.
module snd_ingen #(
  parameter int DATA_W    = 16,
  parameter int HALF_BITS = 32
) (
  input  logic                  BCLK,
  input  logic                  RST_X,
  input  logic                  SND_LRCLK,
  input  logic                  SND_DIN,
  input  logic [1:0]            REG_CMD,
  input  logic [1:0]            REG_DECIM,
  input  logic                  FIFO_FULL,
  output logic                  FIFO_WRITE,
  output logic [2*DATA_W-1:0]   FIFO_DIN,
  output logic [DATA_W-1:0]     L_SNDDATA,
  output logic [DATA_W-1:0]     R_SNDDATA,
  output logic                  LOCKED,
  output logic                  SYNC_ERR,
  output logic [15:0]           OVF_COUNT
);

  localparam int FRAME = 2 * HALF_BITS;
  localparam int PW    = $clog2(FRAME);

  // Frame positions; the completion point wraps when DATA_W == HALF_BITS.
  localparam logic [PW-1:0] P_ZERO  = PW'(0);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [PW-1:0] P_LAST  = PW'(FRAME - 1);
  localparam logic [PW-1:0] P_HALF  = PW'(HALF_BITS);
  localparam logic [PW-1:0] L_END   = PW'(DATA_W - 1);
  localparam logic [PW-1:0] R_START = PW'(HALF_BITS);
  localparam logic [PW-1:0] R_END   = PW'(HALF_BITS + DATA_W - 1);
  localparam logic [PW-1:0] P_COMP  = PW'((HALF_BITS + DATA_W) % FRAME);

  localparam logic [1:0] CMD_CAP = 2'b01;
  localparam logic [1:0] CMD_CLR = 2'b10;

  typedef enum logic [0:0] {
    ST_UNLOCK = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  // Shift one serial bit into the LSB end of a sample register.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    logic [DATA_W-1:0] r;
    r    = v << 1;
    r[0] = b;
    return r;
  endfunction

  state_t                state_q;
  logic                  lr_q;
  logic [PW-1:0]         p_q;
  logic [2:0]            dec_q;
  logic [DATA_W-1:0]     l_sh_q;
  logic [DATA_W-1:0]     r_sh_q;
  logic                  fifo_write_q;
  logic [2*DATA_W-1:0]   fifo_din_q;
  logic [DATA_W-1:0]     l_data_q;
  logic [DATA_W-1:0]     r_data_q;
  logic                  locked_q;
  logic                  sync_err_q;
  logic [15:0]           ovf_q;

  logic                  fall_s;
  logic                  rise_s;
  logic [PW-1:0]         p_inc_s;
  logic [PW-1:0]         pos_s;
  logic                  viol_s;
  logic                  acq_s;
  logic                  track_s;
  logic                  comp_s;
  logic                  elig_s;
  logic                  write_s;
  logic                  ovf_inc_s;
  logic                  shift_l_s;
  logic                  shift_r_s;
  logic [2:0]            dec_mask_s;
  logic [2:0]            dec_inc_s;

  // Decode LRCLK edges, frame position, sync violations and write opportunities.
  always_comb begin
    fall_s = lr_q & ~SND_LRCLK;
    rise_s = ~lr_q & SND_LRCLK;

    if (p_q == P_LAST) begin
      p_inc_s = P_ZERO;
    end else begin
      p_inc_s = p_q + P_ONE;
    end

    // In RUN an LRCLK edge must coincide exactly with its expected position.
    if (state_q == ST_RUN) begin
      viol_s = (fall_s != (p_inc_s == P_ZERO)) | (rise_s != (p_inc_s == P_HALF));
      acq_s  = fall_s & viol_s;
    end else begin
      viol_s = 1'b0;
      acq_s  = fall_s;
    end

    // Position of the bit sampled on this edge; re-acquisition restarts at 0.
    if (acq_s) begin
      pos_s = P_ZERO;
    end else begin
      pos_s = p_inc_s;
    end

    track_s   = acq_s | ((state_q == ST_RUN) & ~viol_s);
    shift_l_s = track_s & (pos_s <= L_END);
    shift_r_s = track_s & (pos_s >= R_START) & (pos_s <= R_END);
    comp_s    = (state_q == ST_RUN) & ~viol_s & (pos_s == P_COMP);
    elig_s    = comp_s & (REG_CMD == CMD_CAP) & (dec_q == 3'd0);
    write_s   = elig_s & ~FIFO_FULL;
    ovf_inc_s = elig_s & FIFO_FULL;

    case (REG_DECIM)
      2'd0:    dec_mask_s = 3'b000;
      2'd1:    dec_mask_s = 3'b001;
      2'd2:    dec_mask_s = 3'b011;
      2'd3:    dec_mask_s = 3'b111;
      default: dec_mask_s = 3'b000;
    endcase
    dec_inc_s = (dec_q + 3'd1) & dec_mask_s;
  end

  // Frame-sync FSM, deserializer, decimation and all registered outputs.
  always_ff @(posedge BCLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q      <= ST_UNLOCK;
      lr_q         <= 1'b0;
      p_q          <= P_ZERO;
      dec_q        <= 3'd0;
      l_sh_q       <= '0;
      r_sh_q       <= '0;
      fifo_write_q <= 1'b0;
      fifo_din_q   <= '0;
      l_data_q     <= '0;
      r_data_q     <= '0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      ovf_q        <= 16'd0;
    end else begin
      lr_q <= SND_LRCLK;

      if (acq_s) begin
        state_q  <= ST_RUN;
        p_q      <= P_ZERO;
        locked_q <= 1'b1;
      end else if (viol_s) begin
        state_q  <= ST_UNLOCK;
        locked_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
        p_q      <= p_inc_s;
        locked_q <= 1'b1;
      end else begin
        locked_q <= 1'b0;
      end

      if (shift_l_s) begin
        l_sh_q <= shift_in(l_sh_q, SND_DIN);
      end
      if (shift_r_s) begin
        r_sh_q <= shift_in(r_sh_q, SND_DIN);
      end

      if (comp_s) begin
        l_data_q <= l_sh_q;
        r_data_q <= r_sh_q;
      end

      fifo_write_q <= write_s;
      if (write_s) begin
        fifo_din_q <= {l_sh_q, r_sh_q};
      end

      // Decimation phase restarts whenever capture is not active or sync is re-acquired.
      if (REG_CMD != CMD_CAP) begin
        dec_q <= 3'd0;
      end else if (acq_s) begin
        dec_q <= 3'd0;
      end else if (comp_s) begin
        dec_q <= dec_inc_s;
      end

      // Clear has priority over a same-cycle increment or set.
      if (REG_CMD == CMD_CLR) begin
        ovf_q      <= 16'd0;
        sync_err_q <= 1'b0;
      end else begin
        if (ovf_inc_s && (ovf_q != 16'hFFFF)) begin
          ovf_q <= ovf_q + 16'd1;
        end
        if (viol_s) begin
          sync_err_q <= 1'b1;
        end
      end
    end
  end

  assign FIFO_WRITE = fifo_write_q;
  assign FIFO_DIN   = fifo_din_q;
  assign L_SNDDATA  = l_data_q;
  assign R_SNDDATA  = r_data_q;
  assign LOCKED     = locked_q;
  assign SYNC_ERR   = sync_err_q;
  assign OVF_COUNT  = ovf_q;

endmodule

// File: tb/tb_snd_ingen.sv
`timescale 1ns/1ps
// Directed bench for snd_ingen: drives framed serial audio, predicts FIFO
// writes into a scoreboard queue and checks them as the DUT emits them.
module tb_snd_ingen;

  logic        BCLK = 1'b0;
  logic        RST_X;
  logic        lrclk;
  logic        din;
  logic [1:0]  cmd;
  logic [1:0]  decim;
  logic        full;
  logic        FIFO_WRITE;
  logic [31:0] FIFO_DIN;
  logic [15:0] L_SNDDATA;
  logic [15:0] R_SNDDATA;
  logic        LOCKED;
  logic        SYNC_ERR;
  logic [15:0] OVF_COUNT;

  snd_ingen #(.DATA_W(16), .HALF_BITS(32)) dut (
    .BCLK       (BCLK),
    .RST_X      (RST_X),
    .SND_LRCLK  (lrclk),
    .SND_DIN    (din),
    .REG_CMD    (cmd),
    .REG_DECIM  (decim),
    .FIFO_FULL  (full),
    .FIFO_WRITE (FIFO_WRITE),
    .FIFO_DIN   (FIFO_DIN),
    .L_SNDDATA  (L_SNDDATA),
    .R_SNDDATA  (R_SNDDATA),
    .LOCKED     (LOCKED),
    .SYNC_ERR   (SYNC_ERR),
    .OVF_COUNT  (OVF_COUNT)
  );

  always #5 BCLK = ~BCLK;

  typedef struct {
    logic [31:0] data;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic        lock_k0;
  logic        lock_k1;

  // Posedge counter used to time-stamp expected writes.
  always @(posedge BCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_write"},  FIFO_WRITE, 0);
    chk({tag, "_din"},    FIFO_DIN,   0);
    chk({tag, "_l"},      L_SNDDATA,  0);
    chk({tag, "_r"},      R_SNDDATA,  0);
    chk({tag, "_locked"}, LOCKED,     0);
    chk({tag, "_syncerr"}, SYNC_ERR,  0);
    chk({tag, "_ovf"},    OVF_COUNT,  0);
  endtask

  // Drive the first n bit slots of a frame; k=0 carries the LRCLK falling edge.
  // clr_k >= 0 pulses REG_CMD=10 for one BCLK at that slot.
  task automatic send_bits(input logic [15:0] l, input logic [15:0] r, input int n,
                           input bit want, input int clr_k);
    logic [1:0] saved;
    saved = cmd;
    for (int k = 0; k < n; k++) begin
      @(negedge BCLK);
      if (k == 0) begin
        lock_k0 = LOCKED;
        if (want) sb.push_back('{data: {l, r}, at: cyc + 49});
      end
      if (k == 1) lock_k1 = LOCKED;
      if (clr_k >= 0 && k == clr_k) begin
        saved = cmd;
        cmd   = 2'b10;
      end else if (clr_k >= 0 && k == clr_k + 1) begin
        cmd = saved;
      end
      lrclk = (k >= 32);
      if (k < 16)                din = l[15-k];
      else if (k >= 32 && k < 48) din = r[47-k];
      else                        din = 1'($urandom_range(1, 0));
    end
  endtask

  // Every FIFO write must match the oldest predicted frame, in data and cycle.
  always @(negedge BCLK) begin
    if (FIFO_WRITE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", FIFO_WRITE, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("fifo_din", FIFO_DIN, mon_e.data);
        chk("write_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_X = 1'b0; lrclk = 1'b1; din = 1'b0; full = 1'b0; cmd = 2'b00; decim = 2'b00;
    repeat (3) @(negedge BCLK);
    check_zero("rst");
    RST_X = 1'b1;
    repeat (3) @(negedge BCLK);
    chk("lock_idle", LOCKED, 0);

    // Basic capture, three identical frames.
    cmd = 2'b01;
    send_bits(16'hA5C3, 16'h1234, 64, 1'b1, -1);
    chk("lock_before_edge", lock_k0, 0);
    chk("lock_after_edge",  lock_k1, 1);
    send_bits(16'hA5C3, 16'h1234, 64, 1'b1, -1);
    send_bits(16'hA5C3, 16'h1234, 64, 1'b1, -1);
    chk("basic_syncerr", SYNC_ERR, 0);
    chk("basic_l", L_SNDDATA, 16'hA5C3);
    chk("basic_r", R_SNDDATA, 16'h1234);
    chk("basic_locked", LOCKED, 1);
    chk("basic_ovf", OVF_COUNT, 0);

    // Overflow accounting with FIFO full, then clear.
    full = 1'b1;
    send_bits(16'h1111, 16'h2222, 64, 1'b0, -1);
    send_bits(16'h3333, 16'h4444, 64, 1'b0, -1);
    full = 1'b0;
    chk("ovf_two", OVF_COUNT, 2);
    chk("ovf_l_updates", L_SNDDATA, 16'h3333);
    send_bits(16'h5A5A, 16'hC3C3, 64, 1'b1, 5);
    chk("ovf_cleared", OVF_COUNT, 0);

    // Decimation by 2.
    decim = 2'd1;
    for (int i = 0; i < 6; i++) begin
      send_bits(16'(i), ~16'(i), 64, (i % 2) == 0, -1);
    end
    decim = 2'd0;
    chk("decim_l", L_SNDDATA, 16'h0005);
    chk("decim_r", R_SNDDATA, 16'hFFFA);

    // Premature falling edge at p=40: error, relock on that edge.
    send_bits(16'hDEAD, 16'hBEEF, 40, 1'b0, -1);
    send_bits(16'hCAFE, 16'hF00D, 64, 1'b1, -1);
    chk("sync_err_set", SYNC_ERR, 1);
    chk("sync_relocked", LOCKED, 1);
    chk("sync_l", L_SNDDATA, 16'hCAFE);
    send_bits(16'h0F0F, 16'hF0F0, 64, 1'b1, 5);
    chk("sync_err_clr", SYNC_ERR, 0);

    // Idle command: samples update, no writes.
    cmd = 2'b00;
    for (int i = 0; i < 4; i++) begin
      send_bits(16'h1000 + 16'(i), 16'h2000 + 16'(i), 64, 1'b0, -1);
      chk("idle_l", L_SNDDATA, 16'h1000 + 16'(i));
      chk("idle_r", R_SNDDATA, 16'h2000 + 16'(i));
    end
    chk("idle_locked", LOCKED, 1);
    chk("idle_ovf", OVF_COUNT, 0);

    // Reset in the middle of a frame.
    cmd = 2'b01;
    send_bits(16'h5555, 16'hAAAA, 20, 1'b0, -1);
    #2;
    RST_X = 1'b0;
    #1;
    check_zero("rst_mid");
    lrclk = 1'b1;
    repeat (3) @(negedge BCLK);
    RST_X = 1'b1;
    repeat (3) @(negedge BCLK);
    chk("post_rst_locked", LOCKED, 0);
    send_bits(16'h7E81, 16'h0180, 64, 1'b1, -1);
    chk("post_rst_l", L_SNDDATA, 16'h7E81);
    repeat (4) @(negedge BCLK);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
